// File: rtl/trap_csr_pkg.sv
// Shared constants for the machine-mode trap/CSR block: CSR addresses,
// status/interrupt bit positions, interrupt cause codes and FSM states.
package trap_csr_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    // mstatus bit positions
    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    // mip/mie bit positions
    localparam int MSIP_BIT = 3;
    localparam int MTIP_BIT = 7;
    localparam int MEIP_BIT = 11;

    // Writable bits of mie
    localparam logic [31:0] MIE_MASK = 32'h0000_0888;

    // Interrupt cause codes
    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    // Run/sleep FSM
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_SLEEP = 1'b1
    } state_t;

endpackage

// File: rtl/trap_csr_counter64.sv
// 64-bit free-running counter with an increment enable and independent
// writes to each 32-bit half. A write to either half suppresses that
// cycle's increment for the whole counter; the other half holds.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    // Counter register: half writes take precedence over the increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 64'd0;
        end else if (we_lo) begin
            count[31:0] <= wdata;
        end else if (we_hi) begin
            count[63:32] <= wdata;
        end else if (inc) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/trap_csr.sv
// Machine-mode trap/CSR responder. Holds the M-mode CSRs and counters,
// applies trap entry and MRET side effects at the commit edge, returns
// gated pending-interrupt lines, a one-cycle front-end redirect, and a
// WFI sleep indication.
//
// Handshake: redirect_valid is a single-cycle strobe with no ready; the
// front end must accept redirect_pc in the cycle redirect_valid is high.
module trap_csr
    import trap_csr_pkg::*;
#(
    parameter int                  PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0] MTVEC_RESET = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                trapped,
    input  logic                mret,
    input  logic                wfi,
    input  logic                retired,
    input  logic [31:0]         ecp,
    input  logic [3:0]          ecause,
    input  logic                interupt,
    input  logic                irq_sw,
    input  logic                irq_timer,
    input  logic                irq_ext,
    input  logic                csr_we,
    input  logic [11:0]         csr_addr,
    input  logic [31:0]         csr_wdata,
    output logic [31:0]         csr_rdata,
    output logic                sip,
    output logic                tip,
    output logic                eip,
    output logic                redirect_valid,
    output logic [PC_WIDTH-1:0] redirect_pc,
    output logic                sleep
);

    logic                mst_mie;
    logic                mst_mpie;
    logic [31:0]         mie_q;
    logic [31:0]         mip_q;
    logic [PC_WIDTH-1:0] mtvec_q;
    logic [31:0]         mscratch_q;
    logic [31:0]         mepc_q;
    logic [31:0]         mcause_q;
    logic [63:0]         mcycle;
    logic [63:0]         minstret;
    state_t              state_q;
    state_t              state_d;

    logic                trap_take;
    logic                mret_take;
    logic                ctl_cycle;
    logic [PC_WIDTH-1:0] vec_base;
    logic [PC_WIDTH-1:0] trap_target;
    logic [31:0]         mip_d;

    assign trap_take = trapped;
    assign mret_take = mret & ~trapped;
    // Trap/MRET own mstatus, mepc and mcause in their cycle
    assign ctl_cycle = trap_take | mret_take;

    logic wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause;
    logic wr_cyc_lo, wr_cyc_hi, wr_ins_lo, wr_ins_hi;

    assign wr_mstatus  = csr_we & (csr_addr == CSR_MSTATUS);
    assign wr_mie      = csr_we & (csr_addr == CSR_MIE);
    assign wr_mtvec    = csr_we & (csr_addr == CSR_MTVEC);
    assign wr_mscratch = csr_we & (csr_addr == CSR_MSCRATCH);
    assign wr_mepc     = csr_we & (csr_addr == CSR_MEPC);
    assign wr_mcause   = csr_we & (csr_addr == CSR_MCAUSE);
    assign wr_cyc_lo   = csr_we & (csr_addr == CSR_MCYCLE);
    assign wr_cyc_hi   = csr_we & (csr_addr == CSR_MCYCLEH);
    assign wr_ins_lo   = csr_we & (csr_addr == CSR_MINSTRET);
    assign wr_ins_hi   = csr_we & (csr_addr == CSR_MINSTRETH);

    // Vectored mode only offsets interrupts; exceptions always go to base
    assign vec_base    = {mtvec_q[PC_WIDTH-1:2], 2'b00};
    assign trap_target = (mtvec_q[1:0] == 2'b01 && interupt)
                       ? vec_base + PC_WIDTH'({ecause, 2'b00})
                       : vec_base;

    // Gated pending lines straight from the registered CSR state
    assign sip = mip_q[MSIP_BIT] & mie_q[MSIP_BIT] & mst_mie;
    assign tip = mip_q[MTIP_BIT] & mie_q[MTIP_BIT] & mst_mie;
    assign eip = mip_q[MEIP_BIT] & mie_q[MEIP_BIT] & mst_mie;

    // Place the raw interrupt levels at their mip bit positions
    always_comb begin
        mip_d           = 32'd0;
        mip_d[MSIP_BIT] = irq_sw;
        mip_d[MTIP_BIT] = irq_timer;
        mip_d[MEIP_BIT] = irq_ext;
    end

    // mstatus MIE/MPIE: trap stacks, MRET unstacks, otherwise CSR write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst_mie  <= 1'b0;
            mst_mpie <= 1'b1;
        end else if (trap_take) begin
            mst_mpie <= mst_mie;
            mst_mie  <= 1'b0;
        end else if (mret_take) begin
            mst_mie  <= mst_mpie;
            mst_mpie <= 1'b1;
        end else if (wr_mstatus) begin
            mst_mie  <= csr_wdata[MSTATUS_MIE_BIT];
            mst_mpie <= csr_wdata[MSTATUS_MPIE_BIT];
        end
    end

    // Plain CSRs that a trap/MRET never touches, plus mip sampling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q      <= 32'd0;
            mip_q      <= 32'd0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= 32'd0;
        end else begin
            mip_q <= mip_d;
            if (wr_mie)      mie_q      <= csr_wdata & MIE_MASK;
            if (wr_mtvec)    mtvec_q    <= PC_WIDTH'(csr_wdata);
            if (wr_mscratch) mscratch_q <= csr_wdata;
        end
    end

    // mepc/mcause: trap capture wins, CSR writes dropped in trap/MRET cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mepc_q   <= 32'd0;
            mcause_q <= 32'd0;
        end else if (trap_take) begin
            mepc_q   <= ecp & ~32'h3;
            mcause_q <= {interupt, 27'd0, ecause};
        end else if (!ctl_cycle) begin
            if (wr_mepc)   mepc_q   <= csr_wdata & ~32'h3;
            if (wr_mcause) mcause_q <= csr_wdata;
        end
    end

    // One-cycle redirect strobe following a trap or MRET edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= ctl_cycle;
            if (trap_take) begin
                redirect_pc <= trap_target;
            end else if (mret_take) begin
                redirect_pc <= PC_WIDTH'(mepc_q);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: wake on any enabled pending interrupt (MIE ignored) or a trap
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (wfi && !trapped) state_d = ST_SLEEP;
            end
            ST_SLEEP: begin
                if (trapped || ((mip_q & mie_q) != 32'd0)) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign sleep = (state_q == ST_SLEEP);

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .we_lo (wr_cyc_lo),
        .we_hi (wr_cyc_hi),
        .wdata (csr_wdata),
        .count (mcycle)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retired),
        .we_lo (wr_ins_lo),
        .we_hi (wr_ins_hi),
        .wdata (csr_wdata),
        .count (minstret)
    );

    // Combinational CSR read mux; unmapped addresses read zero
    always_comb begin
        csr_rdata = 32'd0;
        case (csr_addr)
            CSR_MSTATUS: begin
                csr_rdata[MSTATUS_MIE_BIT]  = mst_mie;
                csr_rdata[MSTATUS_MPIE_BIT] = mst_mpie;
            end
            CSR_MIE:       csr_rdata = mie_q;
            CSR_MTVEC:     csr_rdata = 32'(mtvec_q);
            CSR_MSCRATCH:  csr_rdata = mscratch_q;
            CSR_MEPC:      csr_rdata = mepc_q;
            CSR_MCAUSE:    csr_rdata = mcause_q;
            CSR_MIP:       csr_rdata = mip_q;
            CSR_MCYCLE:    csr_rdata = mcycle[31:0];
            CSR_MCYCLEH:   csr_rdata = mcycle[63:32];
            CSR_MINSTRET:  csr_rdata = minstret[31:0];
            CSR_MINSTRETH: csr_rdata = minstret[63:32];
            default:       csr_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_trap_csr.sv
// Bench for trap_csr: directed scenarios with known answers, then random
// traffic compared cycle by cycle against a behavioural model of the CSRs.
module tb_trap_csr;
    import trap_csr_pkg::*;

    localparam int          PC_WIDTH    = 32;
    localparam logic [31:0] MTVEC_RESET = 32'h0000_0000;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trapped, mret, wfi, retired, interupt;
    logic [31:0] ecp;
    logic [3:0]  ecause;
    logic        irq_sw, irq_timer, irq_ext;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        sip, tip, eip, redirect_valid, sleep;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    trap_csr #(.PC_WIDTH(PC_WIDTH), .MTVEC_RESET(MTVEC_RESET)) dut (
        .clk(clk), .rst_n(rst_n), .trapped(trapped), .mret(mret), .wfi(wfi),
        .retired(retired), .ecp(ecp), .ecause(ecause), .interupt(interupt),
        .irq_sw(irq_sw), .irq_timer(irq_timer), .irq_ext(irq_ext),
        .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .sip(sip), .tip(tip), .eip(eip),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .sleep(sleep)
    );

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];   // expected redirect targets, in order

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_mie, m_mpie, m_sleep, m_rv;
    logic [31:0] m_mie_r, m_mip, m_mtvec, m_mepc, m_mcause, m_mscratch;
    logic [63:0] m_cyc, m_inst;

    task automatic model_reset();
        m_mie = 0; m_mpie = 1; m_sleep = 0; m_rv = 0;
        m_mie_r = 0; m_mip = 0; m_mtvec = MTVEC_RESET; m_mepc = 0;
        m_mcause = 0; m_mscratch = 0; m_cyc = 0; m_inst = 0;
        exp_q.delete();
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
            12'h304: return m_mie_r;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_mip;
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_inst[31:0];
            12'hB82: return m_inst[63:32];
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs applied for it
    task automatic model_step();
        logic [31:0] base, tgt, old_mip, old_mie;
        bit take, ret, blk, cyc_w, inst_w;
        old_mip = m_mip;
        old_mie = m_mie_r;
        take = trapped;
        ret  = mret && !trapped;
        blk  = take || ret;
        base = m_mtvec & ~32'h3;
        m_rv = blk;
        if (take) begin
            tgt = (m_mtvec[1:0] == 2'b01 && interupt) ? base + 32'(ecause) * 4 : base;
            exp_q.push_back(tgt);
            m_mepc   = ecp & ~32'h3;
            m_mcause = (interupt ? 32'h8000_0000 : 32'h0) | 32'(ecause);
            m_mpie   = m_mie;
            m_mie    = 0;
        end else if (ret) begin
            exp_q.push_back(m_mepc);
            m_mie  = m_mpie;
            m_mpie = 1;
        end
        cyc_w = 0;
        inst_w = 0;
        if (csr_we) begin
            case (csr_addr)
                12'h300: if (!blk) begin m_mie = csr_wdata[3]; m_mpie = csr_wdata[7]; end
                12'h304: m_mie_r = csr_wdata & 32'h888;
                12'h305: m_mtvec = csr_wdata;
                12'h340: m_mscratch = csr_wdata;
                12'h341: if (!blk) m_mepc = csr_wdata & ~32'h3;
                12'h342: if (!blk) m_mcause = csr_wdata;
                12'hB00: begin m_cyc[31:0]   = csr_wdata; cyc_w = 1; end
                12'hB80: begin m_cyc[63:32]  = csr_wdata; cyc_w = 1; end
                12'hB02: begin m_inst[31:0]  = csr_wdata; inst_w = 1; end
                12'hB82: begin m_inst[63:32] = csr_wdata; inst_w = 1; end
                default: ;
            endcase
        end
        if (!cyc_w) m_cyc = m_cyc + 1;
        if (!inst_w && retired) m_inst = m_inst + 1;
        m_mip = (irq_sw ? 32'h8 : 32'h0) | (irq_timer ? 32'h80 : 32'h0) | (irq_ext ? 32'h800 : 32'h0);
        if (m_sleep) begin
            if (take || (old_mip & old_mie) != 0) m_sleep = 0;
        end else if (wfi && !take) begin
            m_sleep = 1;
        end
    endtask

    task automatic check_outputs();
        logic [31:0] e;
        check("sip", 32'(sip), 32'(m_mip[3] & m_mie_r[3] & m_mie));
        check("tip", 32'(tip), 32'(m_mip[7] & m_mie_r[7] & m_mie));
        check("eip", 32'(eip), 32'(m_mip[11] & m_mie_r[11] & m_mie));
        check("sleep", 32'(sleep), 32'(m_sleep));
        check("redirect_valid", 32'(redirect_valid), 32'(m_rv));
        if (m_rv && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("redirect_pc", redirect_pc, e);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        trapped = 0; mret = 0; wfi = 0; retired = 0; interupt = 0;
        ecp = 0; ecause = 0; irq_sw = 0; irq_timer = 0; irq_ext = 0;
        csr_we = 0; csr_addr = 0; csr_wdata = 0;
    endtask

    // Called at a falling edge (or time 0)
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic apply_reset();
        rst_n = 0;
        clear_inputs();
        #1;
        model_reset();
        check("rst_redirect_valid", 32'(redirect_valid), 32'h0);
        check("rst_sleep", 32'(sleep), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        csr_we = 1; csr_addr = a; csr_wdata = d;
        tick();
        csr_we = 0;
    endtask

    task automatic read_expect(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_we = 0;
        csr_addr = a;
        #1;
        check(tag, csr_rdata, exp);
    endtask

    logic [11:0] addr_tbl [14] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                   12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h123,
                                   12'hB01, 12'h301};

    // ---------------- stimulus ----------------
    initial begin
        clear_inputs();
        apply_reset();

        // reset values
        read_expect("rst_mtvec", 12'h305, MTVEC_RESET);
        read_expect("rst_mstatus", 12'h300, 32'h80);
        check("rst_eip", 32'(eip), 32'h0);
        check("rst_tip", 32'(tip), 32'h0);
        check("rst_sip", 32'(sip), 32'h0);

        // external interrupt, vectored trap
        csr_write(12'h304, 32'h800);
        csr_write(12'h300, 32'h8);
        csr_write(12'h305, 32'h2001);
        irq_ext = 1;
        tick();
        check("eip_raised", 32'(eip), 32'h1);
        trapped = 1; interupt = 1; ecause = CAUSE_MEI; ecp = 32'h100;
        tick();
        trapped = 0; interupt = 0; ecause = 0; irq_ext = 0;
        check("irq_redirect_valid", 32'(redirect_valid), 32'h1);
        check("irq_redirect_pc", redirect_pc, 32'h202C);
        check("irq_eip_masked", 32'(eip), 32'h0);
        read_expect("irq_mepc", 12'h341, 32'h100);
        read_expect("irq_mcause", 12'h342, 32'h8000_000B);
        read_expect("irq_mstatus", 12'h300, 32'h80);
        tick();
        check("redirect_pulse_end", 32'(redirect_valid), 32'h0);

        // exception goes to base, then MRET restores
        csr_write(12'h300, 32'h8);
        trapped = 1; ecause = 4'd2; ecp = 32'h44;
        tick();
        trapped = 0; ecause = 0;
        check("exc_redirect_pc", redirect_pc, 32'h2000);
        read_expect("exc_mcause", 12'h342, 32'h2);
        read_expect("exc_mstatus", 12'h300, 32'h80);
        mret = 1;
        tick();
        mret = 0;
        check("mret_redirect_valid", 32'(redirect_valid), 32'h1);
        check("mret_redirect_pc", redirect_pc, 32'h44);
        read_expect("mret_mstatus", 12'h300, 32'h88);

        // WFI sleeps, wakes on enabled timer with MIE clear
        csr_write(12'h304, 32'h80);
        csr_write(12'h300, 32'h0);
        wfi = 1;
        tick();
        wfi = 0;
        check("wfi_sleep", 32'(sleep), 32'h1);
        irq_timer = 1;
        tick();
        check("wake_wait", 32'(sleep), 32'h1);
        tick();
        check("wake_sleep", 32'(sleep), 32'h0);
        check("wake_no_redirect", 32'(redirect_valid), 32'h0);
        irq_timer = 0;

        // trap cycle CSR-write priority
        trapped = 1; ecause = 4'd3; ecp = 32'h600;
        csr_we = 1; csr_addr = 12'h341; csr_wdata = 32'h500;
        tick();
        csr_addr = 12'h340; csr_wdata = 32'h55;
        tick();
        trapped = 0; csr_we = 0;
        read_expect("trap_mepc_wins", 12'h341, 32'h600);
        read_expect("trap_mscratch_write", 12'h340, 32'h55);

        // counter carry between halves
        csr_write(12'hB02, 32'hFFFF_FFFF);
        retired = 1;
        tick();
        read_expect("minstret_hi", 12'hB82, 32'h1);
        read_expect("minstret_lo", 12'hB02, 32'h0);
        tick();
        retired = 0;
        read_expect("minstret_lo_next", 12'hB02, 32'h1);
        csr_write(12'hB80, 32'h5);
        csr_write(12'hB00, 32'hFFFF_FFFF);
        read_expect("mcycle_lo_written", 12'hB00, 32'hFFFF_FFFF);
        tick();
        read_expect("mcycle_hi_carry", 12'hB80, 32'h6);
        read_expect("mcycle_lo_wrap", 12'hB00, 32'h0);

        // random traffic against the model, with an asynchronous reset mid-way
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                clear_inputs();
                trapped = 1;
                tick();
                apply_reset();
            end
            trapped   = ($urandom_range(0, 15) == 0);
            mret      = ($urandom_range(0, 15) == 0);
            wfi       = ($urandom_range(0, 23) == 0);
            retired   = 1'($urandom_range(0, 1));
            interupt  = 1'($urandom_range(0, 1));
            ecause    = 4'($urandom_range(0, 15));
            ecp       = $urandom;
            if ($urandom_range(0, 7) == 0) irq_sw = ~irq_sw;
            if ($urandom_range(0, 7) == 0) irq_timer = ~irq_timer;
            if ($urandom_range(0, 7) == 0) irq_ext = ~irq_ext;
            csr_addr  = addr_tbl[$urandom_range(0, 13)];
            csr_we    = ($urandom_range(0, 3) == 0);
            csr_wdata = $urandom;
            #1;
            check("rand_rdata", csr_rdata, model_read(csr_addr));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
